fc_weight_reader: RTL and testbench
===================================

# fc_weight_reader

Read-out side of the fully-connected butterfly layer's weight port. It snapshots the packed per-unit control (weight) bits exposed by the `fc` block and streams them out as bytes over a valid/ready interface. The usual downstream consumer is the UART/debug path, used for dumping trained weights off-chip. It runs in the same clock domain as `fc` and never drives `fc` inputs.

## Interface
- `N`, default 27: width of the `fc` data path; must be a power of 3.
- `NUM_LAYERS`, default `clog3(N)`: derived, not overridden; 3 for N=27.
- `UNITS`, derived as `N/3`: units per layer.
- `BITS`, derived as `NUM_LAYERS*UNITS`: total weight bits (27 for N=27).
- `NUM_BYTES`, derived as `ceil(BITS/8)`: payload bytes (4 for N=27).

Ports:
- `clk_in`, input, 1: system clock; all state on rising edge.
- `rst_in`, input, 1: asynchronous, active-low reset.
- `dump_start`, input, 1: single-cycle request to begin a dump.
- `control_in`, input, `[NUM_LAYERS-1:0][UNITS-1:0]`: weight bits, connected to `fc.control_out`.
- `byte_out`, output, 8: current byte.
- `byte_valid`, output, 1: `byte_out` is valid.
- `byte_ready`, input, 1: consumer accepts the byte when this and `byte_valid` are both high at a rising edge.
- `busy`, output, 1: a dump is in progress.
- `dump_done`, output, 1: one-cycle pulse after the final byte is accepted.

## Operation
- FSM states: IDLE, SEND, CSUM (present only with the macro), DONE.
- **IDLE**
  - `dump_start=1` captures all of `control_in` into the snapshot register `snap[BITS-1:0]`.
  - Flat bit order: `snap[l*UNITS+u] = control_in[l][u]`.
  - Byte index resets to 0, accumulator clears to 0, and the FSM moves to SEND.
- **SEND**
  - `byte_out = snap[8*idx +: 8]`, LSB first.
  - Bits at or above `BITS` read as 0. For N=27, byte 3 carries bits 26..24 in [2:0], with [7:3] = 0.
  - On accept: the accumulator XORs the byte and `idx` increments.
  - On accept of byte `NUM_BYTES-1`: go to CSUM if enabled, otherwise DONE.
- **CSUM**: `byte_out` = accumulator. On accept, go to DONE.
- **DONE**: `dump_done=1` for exactly one cycle, then IDLE.
- Output decode:
  - `busy=1` in SEND and CSUM.
  - `byte_valid=1` in SEND and CSUM.
  - `byte_out=0` whenever `byte_valid=0`.
- `dump_start` is ignored in SEND, CSUM and DONE; no queuing.
- Changes on `control_in` after capture do not affect the dump in progress.
- `byte_out` holds stable while `byte_valid=1` and `byte_ready=0`.
- `idx` width is `$clog2(NUM_BYTES+1)`. It never wraps; the terminal compare is at `NUM_BYTES-1`.

## Timing
- Reset values (asynchronous, while `rst_in=0`):
  - State IDLE; `byte_out=0`, `byte_valid=0`, `busy=0`, `dump_done=0`.
  - `snap=0`, `idx=0`, accumulator 0.
- Reset asserted mid-dump aborts immediately. No `dump_done` is generated, and no partial bytes are emitted after release.
- `dump_start` sampled high at edge t in IDLE: `byte_valid` and `busy` are high from t+1 with byte 0.
- Throughput is 1 byte/cycle with `byte_ready` held high. Next byte is presented the cycle after an accept.
- Last accept at edge t: `busy=0` and `byte_valid=0` from t+1; `dump_done=1` during cycle t+1 only; IDLE from t+2.
- Minimum start-to-start: `NUM_BYTES(+1)+2` cycles. A `dump_start` in the DONE cycle is ignored.
- Simultaneous `dump_start` and accept: the accept proceeds normally; the start is ignored.

## Configuration
- `FC_WEIGHT_DUMP_CHECKSUM_EN` defined:
  - CSUM state is compiled in.
  - One extra byte follows the payload: the XOR of all `NUM_BYTES` payload bytes.
  - Frame is `NUM_BYTES+1` bytes.
- Undefined:
  - No CSUM state and no accumulator.
  - Frame is exactly `NUM_BYTES` bytes; DONE follows the last payload byte.

## Test plan
All scenarios use N=27.
- **All ones:** `control_in` all ones, start, `byte_ready=1`.
  - Bytes `FF FF FF 07`.
  - With the macro, then `F8`.
  - `dump_done` pulses 1 cycle after the last accept.
- **Single bit:** `control_in[0][0]=1` only -> `01 00 00 00`. `control_in[2][8]=1` only -> `00 00 00 04`.
- **Backpressure:** `byte_ready` toggles 1/0 each cycle with pattern `control_in[1]=9'h1AA`.
  - Bytes `00 54 03 00`; each byte is held stable through stall cycles.
  - No byte is duplicated or dropped.
- **Snapshot and ignored start:** capture all ones, then drive `control_in=0` and pulse `dump_start` mid-dump.
  - Stream remains `FF FF FF 07`.
  - No second dump follows.
- **Reset mid-dump:** assert `rst_in=0` after byte 1 is accepted.
  - All outputs read 0 immediately and `dump_done` never pulses.
  - A fresh start after release emits from byte 0.
- **Back-to-back dumps:** start asserted in the first IDLE cycle after `dump_done`.
  - Second frame is identical and begins on the next cycle.

Source files
------------

// File: rtl/fc_weight_reader.sv
// Streams a snapshot of the fc layer's packed weight bits out as bytes, LSB first (optional XOR byte under FC_WEIGHT_DUMP_CHECKSUM_EN).
// Latency: byte 0 is valid the cycle after dump_start; one byte per cycle while byte_ready is high.
// Backpressure: byte_out and byte_valid hold until byte_ready is high.
module fc_weight_reader #(
    parameter int N = 27,
    localparam int NUM_LAYERS = (N <= 1)    ? 0 :
                                (N <= 3)    ? 1 :
                                (N <= 9)    ? 2 :
                                (N <= 27)   ? 3 :
                                (N <= 81)   ? 4 :
                                (N <= 243)  ? 5 :
                                (N <= 729)  ? 6 :
                                (N <= 2187) ? 7 : 8,
    localparam int UNITS     = N / 3,
    localparam int BITS      = NUM_LAYERS * UNITS,
    localparam int NUM_BYTES = (BITS + 7) / 8,
    localparam int IDX_W     = $clog2(NUM_BYTES + 1)
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  dump_start,
    input  logic [NUM_LAYERS-1:0][UNITS-1:0]      control_in,
    output logic [7:0]                            byte_out,
    output logic                                  byte_valid,
    input  logic                                  byte_ready,
    output logic                                  busy,
    output logic                                  dump_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
`ifdef FC_WEIGHT_DUMP_CHECKSUM_EN
        ST_CSUM = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [BITS-1:0]        snap_q, snap_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
`ifdef FC_WEIGHT_DUMP_CHECKSUM_EN
    logic [7:0]             acc_q, acc_d;
`endif

    logic [8*NUM_BYTES-1:0] snap_pad;
    logic [7:0]             payload_byte;
    logic                   accept;
    logic                   last_payload;

    // Bits beyond BITS in the final byte read back as zero.
    assign snap_pad     = (8*NUM_BYTES)'(snap_q);
    assign accept       = byte_valid && byte_ready;
    assign last_payload = (idx_q == IDX_W'(NUM_BYTES - 1));

    always_comb begin
        payload_byte = 8'h00;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
                payload_byte = snap_pad[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
`ifdef FC_WEIGHT_DUMP_CHECKSUM_EN
            acc_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
`ifdef FC_WEIGHT_DUMP_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
`ifdef FC_WEIGHT_DUMP_CHECKSUM_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dump_start) begin
                    // The packed layer/unit array flattens to snap[l*UNITS+u].
                    snap_d  = control_in;
                    idx_d   = '0;
`ifdef FC_WEIGHT_DUMP_CHECKSUM_EN
                    acc_d   = 8'h00;
`endif
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (accept) begin
`ifdef FC_WEIGHT_DUMP_CHECKSUM_EN
                    acc_d = acc_q ^ payload_byte;
`endif
                    idx_d = idx_q + IDX_W'(1);
                    if (last_payload) begin
`ifdef FC_WEIGHT_DUMP_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef FC_WEIGHT_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        byte_out   = 8'h00;
        byte_valid = 1'b0;
        busy       = 1'b0;
        dump_done  = 1'b0;
        case (state_q)
            ST_SEND: begin
                byte_out   = payload_byte;
                byte_valid = 1'b1;
                busy       = 1'b1;
            end
`ifdef FC_WEIGHT_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                byte_out   = acc_q;
                byte_valid = 1'b1;
                busy       = 1'b1;
            end
`endif
            ST_DONE: begin
                dump_done = 1'b1;
            end
            default: begin
                byte_out = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_fc_weight_reader.sv
// Directed bench for fc_weight_reader at N=27: byte streams, backpressure, snapshot, reset abort, back-to-back frames.
module tb_fc_weight_reader;

    logic            clk_in;
    logic            rst_in;
    logic            dump_start;
    logic [2:0][8:0] control_in;
    logic [7:0]      byte_out;
    logic            byte_valid;
    logic            byte_ready;
    logic            busy;
    logic            dump_done;

    int n_tests = 0;
    int n_fail  = 0;
    bit rdy_phase;

`ifdef FC_WEIGHT_DUMP_CHECKSUM_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif

    fc_weight_reader #(.N(27)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .dump_start (dump_start),
        .control_in (control_in),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .dump_done  (dump_done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_dump();
        @(negedge clk_in);
        dump_start = 1'b1;
        @(posedge clk_in);
        #1 dump_start = 1'b0;
    endtask

    // Consumes one frame; payload holds the expected bytes LSB first.
    task automatic collect(input string nm, input logic [31:0] payload, input bit stall,
                           input bit poke, input bit b2b);
        logic [7:0] exp_b;
        logic [7:0] csum;
        int         cyc;
        bit         acc;
        csum = payload[7:0] ^ payload[15:8] ^ payload[23:16] ^ payload[31:24];
        for (int k = 0; k < FRAME; k++) begin
            exp_b = (k < 4) ? payload[8*k +: 8] : csum;
            cyc   = 0;
            acc   = 1'b0;
            while (!acc) begin
                @(negedge clk_in);
                check({nm, "_valid"}, 32'(byte_valid), 32'd1);
                check({nm, "_busy"},  32'(busy), 32'd1);
                check({nm, $sformatf("_byte%0d", k)}, 32'(byte_out), 32'(exp_b));
                if (poke && k >= 2) control_in = '0;
                dump_start = poke && (k == 2) && (cyc == 0);
                if (stall) begin
                    byte_ready = rdy_phase;
                    rdy_phase  = ~rdy_phase;
                end else begin
                    byte_ready = 1'b1;
                end
                acc = byte_ready;
                cyc++;
                @(posedge clk_in);
                if (cyc > 20) begin
                    check({nm, "_timeout"}, 32'(cyc), 32'd20);
                    break;
                end
            end
        end
        #1 dump_start = 1'b0;
        byte_ready = 1'b0;
        @(negedge clk_in);
        check({nm, "_done_pulse"}, 32'(dump_done), 32'd1);
        check({nm, "_done_busy"},  32'(busy), 32'd0);
        check({nm, "_done_valid"}, 32'(byte_valid), 32'd0);
        check({nm, "_done_byte"},  32'(byte_out), 32'd0);
        @(negedge clk_in);
        check({nm, "_done_clear"}, 32'(dump_done), 32'd0);
        check({nm, "_idle_busy"},  32'(busy), 32'd0);
        if (b2b) begin
            dump_start = 1'b1;
            @(posedge clk_in);
            #1 dump_start = 1'b0;
        end
    endtask

    initial begin
        rst_in     = 1'b0;
        dump_start = 1'b0;
        byte_ready = 1'b0;
        control_in = '0;
        rdy_phase  = 1'b0;
        #3;
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_byte",  32'(byte_out), 32'd0);
        check("rst_done",  32'(dump_done), 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);

        // All ones: FF FF FF 07 (+ F8)
        control_in = '1;
        start_dump();
        collect("ones", 32'h07FF_FFFF, 1'b0, 1'b0, 1'b0);

        // Single bits
        control_in = '0;
        control_in[0][0] = 1'b1;
        start_dump();
        collect("bit00", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        control_in = '0;
        control_in[2][8] = 1'b1;
        start_dump();
        collect("bit28", 32'h0400_0000, 1'b0, 1'b0, 1'b0);

        // Backpressure: 00 54 03 00
        control_in = '0;
        control_in[1] = 9'h1AA;
        rdy_phase = 1'b0;
        start_dump();
        collect("bp", 32'h0003_5400, 1'b1, 1'b0, 1'b0);

        // Snapshot isolation and ignored start mid-dump
        control_in = '1;
        start_dump();
        collect("snap", 32'h07FF_FFFF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("snap_no_second", 32'(busy), 32'd0);
        end

        // Reset mid-dump after byte 1 accepted
        control_in = '1;
        start_dump();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_in);
            check($sformatf("rstm_byte%0d", k), 32'(byte_out), 32'hFF);
            byte_ready = 1'b1;
            @(posedge clk_in);
        end
        #2 rst_in = 1'b0;
        byte_ready = 1'b0;
        #1;
        check("rstm_valid", 32'(byte_valid), 32'd0);
        check("rstm_busy",  32'(busy), 32'd0);
        check("rstm_byte",  32'(byte_out), 32'd0);
        check("rstm_done",  32'(dump_done), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("rstm_after_valid", 32'(byte_valid), 32'd0);
            check("rstm_after_done",  32'(dump_done), 32'd0);
        end
        start_dump();
        collect("rstm_fresh", 32'h07FF_FFFF, 1'b0, 1'b0, 1'b0);

        // Back-to-back frames
        control_in = '0;
        control_in[1] = 9'h1AA;
        start_dump();
        collect("b2b_a", 32'h0003_5400, 1'b0, 1'b0, 1'b1);
        collect("b2b_b", 32'h0003_5400, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
